// File: rtl/ddr_tx_serializer.sv
// Slices wide stream words into per-cycle (dp, dn) lane pairs for a dual-edge output flop.
// A single holding register lets the next word follow the current one with no idle beat.
module ddr_tx_serializer #(
  parameter int DATA_WIDTH = 1,
  parameter int BEATS = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE = '0,
  localparam int WORD_WIDTH = 2*DATA_WIDTH*BEATS,
  localparam int CNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] dp,
  output logic [DATA_WIDTH-1:0] dn,
  output logic                  frame,
  output logic                  active,
  output logic                  idle_entry
);

  localparam int LANE_PAIR = 2*DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BEATS-1);

  logic                  busy, busy_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic                  hold_valid, hold_valid_nxt;
  logic [WORD_WIDTH-1:0] hb, hb_nxt;
  logic [WORD_WIDTH-1:0] sr, sr_nxt, sr_shift;
  logic [DATA_WIDTH-1:0] dp_nxt, dn_nxt;
  logic                  frame_nxt, active_nxt, idle_entry_nxt;
  logic                  slot_free, accept;

  assign s_ready   = !hold_valid;
  assign accept    = s_valid && s_ready;
  assign slot_free = !busy || (cnt == LAST_CNT);
  // sr always holds the current beat in its low lane pair; shifting exposes the next one
  assign sr_shift  = sr >> LANE_PAIR;

  always_comb begin
    busy_nxt       = busy;
    cnt_nxt        = cnt;
    hold_valid_nxt = hold_valid;
    hb_nxt         = hb;
    sr_nxt         = sr;
    dp_nxt         = dp;
    dn_nxt         = dn;
    frame_nxt      = 1'b0;
    active_nxt     = active;
    idle_entry_nxt = 1'b0;

    if (slot_free && hold_valid) begin
      sr_nxt         = hb;
      dp_nxt         = hb[DATA_WIDTH-1:0];
      dn_nxt         = hb[LANE_PAIR-1:DATA_WIDTH];
      frame_nxt      = 1'b1;
      active_nxt     = 1'b1;
      busy_nxt       = 1'b1;
      cnt_nxt        = '0;
      hold_valid_nxt = 1'b0;
    end else if (slot_free && accept) begin
      sr_nxt     = s_data;
      dp_nxt     = s_data[DATA_WIDTH-1:0];
      dn_nxt     = s_data[LANE_PAIR-1:DATA_WIDTH];
      frame_nxt  = 1'b1;
      active_nxt = 1'b1;
      busy_nxt   = 1'b1;
      cnt_nxt    = '0;
    end else if (slot_free) begin
      dp_nxt         = IDLE;
      dn_nxt         = IDLE;
      active_nxt     = 1'b0;
      busy_nxt       = 1'b0;
      idle_entry_nxt = busy;
    end else begin
      cnt_nxt    = cnt + CNT_WIDTH'(1);
      sr_nxt     = sr_shift;
      dp_nxt     = sr_shift[DATA_WIDTH-1:0];
      dn_nxt     = sr_shift[LANE_PAIR-1:DATA_WIDTH];
      active_nxt = 1'b1;
      if (accept) begin
        hb_nxt         = s_data;
        hold_valid_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      cnt        <= '0;
      hold_valid <= 1'b0;
      hb         <= '0;
      sr         <= '0;
      dp         <= IDLE;
      dn         <= IDLE;
      frame      <= 1'b0;
      active     <= 1'b0;
      idle_entry <= 1'b0;
    end else begin
      busy       <= busy_nxt;
      cnt        <= cnt_nxt;
      hold_valid <= hold_valid_nxt;
      hb         <= hb_nxt;
      sr         <= sr_nxt;
      dp         <= dp_nxt;
      dn         <= dn_nxt;
      frame      <= frame_nxt;
      active     <= active_nxt;
      idle_entry <= idle_entry_nxt;
    end
  end

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Self-checking bench for ddr_tx_serializer (DATA_WIDTH=4, BEATS=4): directed vector table,
// hand-written corner sequences and random traffic against a word-schedule reference model.
module tb_ddr_tx_serializer;
  localparam int DW = 4;
  localparam int NB = 4;
  localparam int WW = 2*DW*NB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [WW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] dp, dn;
  logic          frame, active, idle_entry;

  ddr_tx_serializer #(.DATA_WIDTH(DW), .BEATS(NB), .IDLE(4'h0)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dp(dp), .dn(dn), .frame(frame), .active(active), .idle_entry(idle_entry)
  );

  always #5 clk = ~clk;

  // Reference: each accepted word gets a start edge = max(accept edge, previous start + NB)
  typedef struct {
    logic [31:0] word;
    int          start;
  } sched_t;
  sched_t q[$];

  typedef struct {
    logic [31:0] word;
    logic [15:0] edp;
    logic [15:0] edn;
  } vec_t;
  vec_t vecs[4];

  int cyc = 0;
  int last_start = -1000;
  bit model_ready = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_check();
    logic [31:0] e_dp, e_dn;
    bit e_act, e_fr, ended;
    int k;
    e_dp = 0; e_dn = 0; e_act = 0; e_fr = 0; ended = 0;
    foreach (q[i]) begin
      if (cyc >= q[i].start && cyc < q[i].start + NB) begin
        k = cyc - q[i].start;
        e_act = 1;
        e_fr = (k == 0);
        e_dp = (q[i].word >> (8*k)) & 32'hF;
        e_dn = (q[i].word >> (8*k + 4)) & 32'hF;
      end else if (q[i].start + NB == cyc) begin
        ended = 1;
      end
    end
    model_ready = !(last_start > cyc);
    chk("dp", 32'(dp), e_dp);
    chk("dn", 32'(dn), e_dn);
    chk("active", 32'(active), 32'(e_act));
    chk("frame", 32'(frame), 32'(e_fr));
    chk("idle_entry", 32'(idle_entry), 32'(ended && !e_act));
    chk("s_ready", 32'(s_ready), 32'(model_ready));
  endtask

  task automatic tick();
    bit acc;
    logic [31:0] d;
    int st;
    acc = s_valid && model_ready;
    d = s_data;
    @(posedge clk);
    cyc++;
    if (acc) begin
      st = (cyc > last_start + NB) ? cyc : last_start + NB;
      q.push_back('{d, st});
      last_start = st;
    end
    #1;
    model_check();
    while (q.size() > 0 && q[0].start + NB < cyc - 2) void'(q.pop_front());
  endtask

  // Offers a word until the model says it is taken; garbage is shown while stalled.
  task automatic send(input logic [31:0] w, input bit garbage);
    bit done;
    done = 0;
    s_valid = 1'b1;
    for (int t = 0; t < 2*NB + 2 && !done; t++) begin
      s_data = (model_ready || !garbage) ? w : $urandom;
      done = model_ready;
      tick();
    end
    chk("send_timeout", 32'(done), 32'd1);
  endtask

  task automatic reset_model();
    q.delete();
    last_start = -1000;
    model_ready = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dp"}, 32'(dp), 32'd0);
    chk({tag, "_dn"}, 32'(dn), 32'd0);
    chk({tag, "_active"}, 32'(active), 32'd0);
    chk({tag, "_frame"}, 32'(frame), 32'd0);
    chk({tag, "_idle_entry"}, 32'(idle_entry), 32'd0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h12345678, 16'h2468, 16'h1357};
    vecs[1] = '{32'h0000A5C3, 16'h0053, 16'h00AC};
    vecs[2] = '{32'hFEDCBA98, 16'hECA8, 16'hFDB9};
    vecs[3] = '{32'h80000001, 16'h0001, 16'h8000};

    // Reset held with the clock running, then quiet idle
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("in_reset");
    rst_n = 1'b1;
    reset_model();
    repeat (10) tick();

    // Directed vectors, each sent into an idle block
    foreach (vecs[v]) begin
      s_valid = 1'b1;
      s_data = vecs[v].word;
      tick();
      s_valid = 1'b0;
      for (int k = 0; k < NB; k++) begin
        if (k > 0) tick();
        chk("vec_dp", 32'(dp), 32'(vecs[v].edp[4*k +: 4]));
        chk("vec_dn", 32'(dn), 32'(vecs[v].edn[4*k +: 4]));
        chk("vec_frame", 32'(frame), 32'(k == 0));
      end
      tick();
      chk("vec_idle_entry", 32'(idle_entry), 32'd1);
      chk("vec_idle_active", 32'(active), 32'd0);
      tick();
      chk("vec_idle_entry_once", 32'(idle_entry), 32'd0);
      tick();
    end

    // Back-to-back with garbage data presented while the hold is full
    send(32'h00010001, 1'b1);
    send(32'h00020002, 1'b1);
    send(32'h00030003, 1'b1);
    send(32'h00040004, 1'b1);
    s_valid = 1'b0;
    repeat (3*NB) tick();

    // Gap of three idle cycles between two single-cycle offers
    send(32'h11111111, 1'b0);
    s_valid = 1'b0;
    repeat (3) tick();
    send(32'h2222C0DE, 1'b0);
    s_valid = 1'b0;
    repeat (2*NB) tick();

    // Reset during beat 1 with the hold full
    send(32'hAAAA5555, 1'b0);
    send(32'hBBBB6666, 1'b0);
    s_valid = 1'b0;
    chk("pre_reset_hold_full", 32'(s_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_valid = 1'b1;
    s_data = 32'h12345678;
    tick();
    s_valid = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (k > 0) tick();
      chk("post_reset_dp", 32'(dp), 32'(vecs[0].edp[4*k +: 4]));
      chk("post_reset_dn", 32'(dn), 32'(vecs[0].edn[4*k +: 4]));
    end
    repeat (3) tick();

    // Random traffic; data held stable while stalled
    for (int i = 0; i < 1500; i++) begin
      if (!(s_valid && !model_ready)) begin
        s_valid = ($urandom_range(0, 99) < 60);
        s_data = $urandom;
      end
      tick();
    end
    s_valid = 1'b0;
    repeat (3*NB) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
